frame_register_file: RTL and testbench

- Parametrised successor to the fixed 16x160 register file: DEPTH x DATA_W storage, NUM_RD independent read ports, optional registered reads.
- Adds a streaming append port with auto-incrementing write pointer, frame-complete signalling and hold/overwrite modes, so the analysis front end can fill one LPC frame (default 160 samples) without generating addresses.
- Sits between the sample acquisition stage and the autocorrelation/LPC stages, which read the frame randomly.

---
 rtl/lpc_pkg.sv | 6 +
 rtl/frame_wptr_ctrl.sv | 53 +++++
 rtl/frame_register_file.sv | 101 ++++++++++
 tb/tb_frame_register_file.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Frame geometry shared by the LPC analysis chain (acquisition, register file, autocorrelation).
package lpc_pkg;
  localparam int LPC_FRAME_LEN = 160;
  localparam int SAMPLE_W      = 16;
  localparam int LPC_ADDR_W    = 8;
endpackage

// File: rtl/frame_wptr_ctrl.sv
// Stream write pointer and frame state for the frame register file.
// Latency: pointer/frame flags update at the accepting edge; frame_done is 1 cycle after the last accept.
// Backpressure: s_ready drops for addressed writes, clr, and a held frame when HOLD_ON_FULL is set.
module frame_wptr_ctrl
  import lpc_pkg::*;
#(
  parameter int DEPTH        = LPC_FRAME_LEN,
  parameter int ADDR_W       = LPC_ADDR_W,
  parameter int HOLD_ON_FULL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic              clr,
  input  logic              s_valid,
  input  logic              frame_ack,
  output logic              s_ready,
  output logic              s_accept,
  output logic [ADDR_W-1:0] wptr,
  output logic              frame_done,
  output logic              frame_valid
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic last_acc;

  assign s_ready  = reset && !wen && !clr && !((HOLD_ON_FULL != 0) && frame_valid);
  assign s_accept = s_valid && s_ready;
  assign last_acc = s_accept && (wptr == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else if (clr) begin
      wptr        <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= last_acc;
      if (s_accept)
        wptr <= last_acc ? '0 : wptr + 1'b1;
      // Completion beats a same-cycle ack so the fresh frame is never lost.
      if (last_acc)
        frame_valid <= 1'b1;
      else if (frame_ack)
        frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_register_file.sv
// DEPTH x DATA_W frame store with addressed writes, a streaming append port and NUM_RD read ports.
// Latency: reads 0 cycles (READ_REG=0) or 1 cycle with write-first bypass (READ_REG=1).
// Backpressure: stream stalls on addressed write, clr, or a held full frame (HOLD_ON_FULL=1).
module frame_register_file
  import lpc_pkg::*;
#(
  parameter int DATA_W       = SAMPLE_W,
  parameter int DEPTH        = LPC_FRAME_LEN,
  parameter int NUM_RD       = 2,
  parameter int ADDR_W       = LPC_ADDR_W,
  parameter int READ_REG     = 1,
  parameter int HOLD_ON_FULL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wen,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  input  logic                     clr,
  input  logic                     frame_ack,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] dout,
  output logic [ADDR_W-1:0]        wptr,
  output logic                     frame_done,
  output logic                     frame_valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              s_accept;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  frame_wptr_ctrl #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .HOLD_ON_FULL (HOLD_ON_FULL)
  ) u_wptr (
    .clk         (clk),
    .reset       (reset),
    .wen         (wen),
    .clr         (clr),
    .s_valid     (s_valid),
    .frame_ack   (frame_ack),
    .s_ready     (s_ready),
    .s_accept    (s_accept),
    .wptr        (wptr),
    .frame_done  (frame_done),
    .frame_valid (frame_valid)
  );

  // Single merged write port: clr blocks everything, addressed write beats the stream.
  always_comb begin
    we = 1'b0;
    wa = waddr;
    wd = din;
    if (reset && !clr) begin
      if (wen) begin
        we = (int'(waddr) < DEPTH);
      end else if (s_accept) begin
        we = 1'b1;
        wa = wptr;
        wd = s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_now;

    assign ra     = raddr[k*ADDR_W +: ADDR_W];
    assign rd_now = (int'(ra) < DEPTH) ? mem[ra] : '0;

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          q <= '0;
        else
          q <= (we && (wa == ra)) ? wd : rd_now;
      end
      assign dout[k*DATA_W +: DATA_W] = q;
    end else begin : g_comb
      assign dout[k*DATA_W +: DATA_W] = rd_now;
    end
  end

endmodule

// File: tb/tb_frame_register_file.sv
// Directed + randomized bench for frame_register_file against an array-based frame model.
module tb_frame_register_file;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Held-frame, registered-read instance
  logic        wen, s_valid, clr, frame_ack;
  logic [7:0]  waddr;
  logic [15:0] din, s_data, raddr;
  logic        s_ready, frame_done, frame_valid;
  logic [31:0] dout;
  logic [7:0]  wptr;

  // Circular, combinational-read instance
  logic        h_wen, h_s_valid, h_clr, h_frame_ack;
  logic [7:0]  h_waddr;
  logic [15:0] h_din, h_s_data, h_raddr;
  logic        h_s_ready, h_frame_done, h_frame_valid;
  logic [31:0] h_dout;
  logic [7:0]  h_wptr;

  frame_register_file #(.READ_REG(1), .HOLD_ON_FULL(1)) u0 (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .din(din),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .clr(clr),
    .frame_ack(frame_ack), .raddr(raddr), .dout(dout), .wptr(wptr),
    .frame_done(frame_done), .frame_valid(frame_valid)
  );

  frame_register_file #(.READ_REG(0), .HOLD_ON_FULL(0)) u1 (
    .clk(clk), .reset(reset), .wen(h_wen), .waddr(h_waddr), .din(h_din),
    .s_valid(h_s_valid), .s_data(h_s_data), .s_ready(h_s_ready), .clr(h_clr),
    .frame_ack(h_frame_ack), .raddr(h_raddr), .dout(h_dout), .wptr(h_wptr),
    .frame_done(h_frame_done), .frame_valid(h_frame_valid)
  );

  logic [15:0] m_mem [160];
  int          m_wptr;
  bit          m_fv, m_fd;
  int          total, bad, fd_seen, h_fd;
  bit          rdy_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 160; i++) m_mem[i] = 16'h0;
    m_wptr = 0;
    m_fv   = 1'b0;
    m_fd   = 1'b0;
  endtask

  // One clock of u0: check s_ready against the frame rules, advance the model, check outputs.
  task automatic cyc();
    bit          rdy, done;
    int          a0, a1;
    logic [15:0] e0, e1;
    #1;
    rdy = !wen && !clr && !m_fv;
    chk("s_ready", {31'b0, s_ready}, {31'b0, rdy});
    done = 1'b0;
    if (clr) begin
      m_wptr = 0;
      m_fv   = 1'b0;
    end else begin
      if (wen) begin
        if (waddr < 160) m_mem[waddr] = din;
      end else if (s_valid && rdy) begin
        m_mem[m_wptr] = s_data;
        if (m_wptr == 159) begin
          m_wptr = 0;
          done   = 1'b1;
        end else begin
          m_wptr++;
        end
      end
      if (done) m_fv = 1'b1;
      else if (frame_ack) m_fv = 1'b0;
    end
    m_fd = done;
    a0 = int'(raddr[7:0]);
    a1 = int'(raddr[15:8]);
    e0 = (a0 < 160) ? m_mem[a0] : 16'h0;
    e1 = (a1 < 160) ? m_mem[a1] : 16'h0;
    @(posedge clk); #1;
    chk("wptr", {24'b0, wptr}, m_wptr);
    chk("frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    chk("dout0", {16'b0, dout[15:0]}, {16'b0, e0});
    chk("dout1", {16'b0, dout[31:16]}, {16'b0, e1});
    if (frame_done) fd_seen++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; fd_seen = 0; h_fd = 0;
    reset = 1'b0;
    wen = 0; waddr = 0; din = 0; s_valid = 0; s_data = 0; clr = 0; frame_ack = 0; raddr = 0;
    h_wen = 0; h_waddr = 0; h_din = 0; h_s_valid = 0; h_s_data = 0; h_clr = 0;
    h_frame_ack = 0; h_raddr = 0;
    m_reset();

    // Reset state
    #12;
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_wptr", {24'b0, wptr}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_fv", {31'b0, frame_valid}, 32'd0);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("release_s_ready", {31'b0, s_ready}, 32'd1);

    // Full frame of k=0..159
    raddr = {8'd159, 8'd0};
    for (int k = 0; k < 160; k++) begin
      s_valid = 1'b1;
      s_data  = 16'(k);
      cyc();
      if (k == 159) chk("last_done", {31'b0, frame_done}, 32'd1);
    end
    s_valid = 1'b0;
    chk("full_wptr", {24'b0, wptr}, 32'd0);
    chk("full_fv", {31'b0, frame_valid}, 32'd1);
    cyc();
    chk("full_fd_drop", {31'b0, frame_done}, 32'd0);
    chk("full_hold_rdy", {31'b0, s_ready}, 32'd0);
    chk("full_rd0", {16'b0, dout[15:0]}, 32'h0000);
    chk("full_rd1", {16'b0, dout[31:16]}, 32'h009F);
    chk("full_pulses", fd_seen, 32'd1);

    // Ack releases the stream
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    chk("ack_rdy", {31'b0, s_ready}, 32'd1);

    // Addressed write collides with the stream
    wen = 1'b1; waddr = 8'd9; din = 16'hABCD; s_valid = 1'b1; s_data = 16'h0500;
    cyc();
    chk("coll_wptr", {24'b0, wptr}, 32'd0);
    wen = 1'b0;
    raddr = {8'd0, 8'd9};
    cyc();
    s_valid = 1'b0;
    chk("coll_accept_wptr", {24'b0, wptr}, 32'd1);
    chk("coll_mem9", {16'b0, dout[15:0]}, 32'hABCD);
    chk("coll_mem0", {16'b0, dout[31:16]}, 32'h0500);

    // Write-first bypass
    raddr = {8'd0, 8'd5};
    wen = 1'b1; waddr = 8'd5; din = 16'h1234;
    cyc();
    wen = 1'b0;
    chk("bypass", {16'b0, dout[15:0]}, 32'h1234);

    // Refill with ack on the final accept
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_wptr", {24'b0, wptr}, 32'd0);
    for (int k = 0; k < 160; k++) begin
      s_valid   = 1'b1;
      s_data    = 16'h1000 + 16'(k);
      frame_ack = (k == 159);
      cyc();
    end
    s_valid = 1'b0; frame_ack = 1'b0;
    chk("race_fv", {31'b0, frame_valid}, 32'd1);
    chk("race_fd", {31'b0, frame_done}, 32'd1);

    // Out-of-range write and read
    raddr = {8'd72, 8'd40};
    wen = 1'b1; waddr = 8'd200; din = 16'hFFFF;
    cyc();
    wen = 1'b0;
    cyc();
    chk("oob_wr_alias40", {16'b0, dout[15:0]}, 32'h1028);
    chk("oob_wr_alias72", {16'b0, dout[31:16]}, 32'h1048);
    raddr = {8'd170, 8'd3};
    cyc();
    chk("oob_rd", {16'b0, dout[31:16]}, 32'h0);

    // clr after 50 samples keeps memory
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    for (int k = 0; k < 50; k++) begin
      s_valid = 1'b1;
      s_data  = 16'h2000 + 16'(k);
      cyc();
    end
    s_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr50_wptr", {24'b0, wptr}, 32'd0);
    raddr = {8'd49, 8'd0};
    cyc();
    chk("clr50_mem0", {16'b0, dout[15:0]}, 32'h2000);
    chk("clr50_mem49", {16'b0, dout[31:16]}, 32'h2031);

    // Reset mid-frame
    for (int k = 0; k < 30; k++) begin
      s_valid = 1'b1;
      s_data  = 16'h3000 + 16'(k);
      cyc();
    end
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mrst_dout", dout, 32'd0);
    chk("mrst_wptr", {24'b0, wptr}, 32'd0);
    chk("mrst_fd", {31'b0, frame_done}, 32'd0);
    chk("mrst_rdy", {31'b0, s_ready}, 32'd0);
    m_reset();
    fd_seen = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      cyc();
    end
    s_valid = 1'b0;
    chk("mrst_no_done", fd_seen, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wen       = ($urandom_range(0, 3) == 0);
      waddr     = 8'($urandom_range(0, 200));
      din       = 16'($urandom);
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 16'($urandom);
      clr       = ($urandom_range(0, 63) == 0);
      frame_ack = ($urandom_range(0, 7) == 0);
      raddr[7:0]  = $urandom_range(0, 1) ? 8'(m_wptr) : 8'($urandom_range(0, 180));
      raddr[15:8] = $urandom_range(0, 1) ? waddr : 8'($urandom_range(0, 180));
      cyc();
    end
    wen = 0; s_valid = 0; clr = 0; frame_ack = 0;

    // Circular overwrite instance
    rdy_ok = 1'b1;
    for (int k = 0; k < 320; k++) begin
      h_s_valid = 1'b1;
      h_s_data  = 16'(k);
      #1;
      if (!h_s_ready) rdy_ok = 1'b0;
      @(posedge clk); #1;
      if (h_frame_done) h_fd++;
    end
    h_s_valid = 1'b0;
    @(posedge clk); #1;
    if (h_frame_done) h_fd++;
    h_raddr = {8'd159, 8'd0};
    #1;
    chk("circ_pulses", h_fd, 32'd2);
    chk("circ_rdy", {31'b0, rdy_ok}, 32'd1);
    chk("circ_mem0", {16'b0, h_dout[15:0]}, 32'd160);
    chk("circ_mem159", {16'b0, h_dout[31:16]}, 32'd319);
    chk("circ_wptr", {24'b0, h_wptr}, 32'd0);
    chk("circ_fv", {31'b0, h_frame_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
